// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared encodings and defaults for the 4-way round-robin mux arbiter.
// Purely declarative: no logic, no latency, no flow control.
package mux4_rr_arbiter_pkg;

  localparam int NUM_REQ      = 4;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Round-robin winner pick: rotate req by ptr, lowest-index priority, rotate back.
// Combinational, zero latency; no backpressure.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic               any,
  output logic [1:0]         win
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [1:0]           off;

  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl[{1'b0, ptr} +: NUM_REQ];
    off     = 2'd0;
    // Walk downward so the lowest set position (closest to ptr) is kept.
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        off = 2'(j);
      end
    end
    any = |req;
    win = off + ptr;
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a 4:1 single-bit mux; grant/sel/valid registered one edge after req.
// No preemption: a grant ends on owner req drop or MAX_HOLD timeout, then one forced idle cycle.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [NUM_REQ-1:0]  data_in,
  output logic [NUM_REQ-1:0]  grant,
  output logic [1:0]          sel,
  output logic                valid,
  output logic                data_out
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [1:0]         sel_q, sel_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [1:0]         ptr_q, ptr_d;

  logic               pick_any;
  logic [1:0]         pick_win;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .win (pick_win)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    valid_d    = valid_q;
    hold_cnt_d = hold_cnt_q;
    ptr_d      = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d    = ST_BUSY;
          grant_d    = onehot4(pick_win);
          sel_d      = pick_win;
          valid_d    = 1'b1;
          hold_cnt_d = '0;
        end
      end
      ST_BUSY: begin
        // sel is left as-is on release; only grant/valid mark the idle cycle.
        if (!req[sel_q] || (hold_cnt_q == HOLD_LAST)) begin
          state_d = ST_IDLE;
          grant_d = '0;
          valid_d = 1'b0;
          ptr_d   = sel_q + 2'd1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      sel_q      <= 2'b00;
      valid_q    <= 1'b0;
      hold_cnt_q <= '0;
      ptr_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      hold_cnt_q <= hold_cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  assign grant    = grant_q;
  assign sel      = sel_q;
  assign valid    = valid_q;
  assign data_out = valid_q & data_in[sel_q];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: vector table plus hand-written timeout/reset/pointer sequences.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] data_in;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       valid;
  logic       data_out;

  int n_vec = 0;
  int n_bad = 0;

  mux4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .data_in  (data_in),
    .grant    (grant),
    .sel      (sel),
    .valid    (valid),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       edge_en;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] g;
    logic [1:0] s;
    logic       v;
    logic       d;
  } vec_t;

  vec_t vecs[32];
  int   nv = 0;

  task automatic add(input logic rst, input logic e, input logic [3:0] r, input logic [3:0] di,
                     input logic [3:0] g, input logic [1:0] s, input logic v, input logic d);
    vecs[nv] = '{rst: rst, edge_en: e, req: r, din: di, g: g, s: s, v: v, d: d};
    nv++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] eg, input logic [1:0] es,
                     input logic ev, input logic ed);
    n_vec++;
    if (grant !== eg || sel !== es || valid !== ev || data_out !== ed) begin
      n_bad++;
      $display("FAIL %s: got grant=%b sel=%b valid=%b data_out=%b, want grant=%b sel=%b valid=%b data_out=%b",
               name, grant, sel, valid, data_out, eg, es, ev, ed);
    end
  endtask

  initial begin
    reset   = 1'b1;
    req     = 4'b0000;
    data_in = 4'b0000;

    // reset priority
    add(1, 1, 4'b1111, 4'b0000, 4'b0000, 2'b00, 0, 0);
    add(1, 1, 4'b1111, 4'b0000, 4'b0000, 2'b00, 0, 0);
    add(1, 1, 4'b1111, 4'b0000, 4'b0000, 2'b00, 0, 0);
    add(0, 1, 4'b1111, 4'b0001, 4'b0001, 2'b00, 1, 1);
    add(0, 1, 4'b0000, 4'b0001, 4'b0000, 2'b00, 0, 0);  // ptr -> 1
    // single requester, combinational data path, release keeps sel
    add(0, 1, 4'b0100, 4'b0100, 4'b0100, 2'b10, 1, 1);
    add(0, 1, 4'b0100, 4'b0000, 4'b0100, 2'b10, 1, 0);
    add(0, 0, 4'b0100, 4'b0100, 4'b0100, 2'b10, 1, 1);
    add(0, 0, 4'b0100, 4'b0000, 4'b0100, 2'b10, 1, 0);
    add(0, 1, 4'b0000, 4'b0000, 4'b0000, 2'b10, 0, 0);  // ptr -> 3
    // rotation from a fresh reset
    add(1, 1, 4'b0000, 4'b1010, 4'b0000, 2'b00, 0, 0);
    add(0, 1, 4'b1111, 4'b1010, 4'b0001, 2'b00, 1, 0);
    add(0, 1, 4'b1110, 4'b1010, 4'b0000, 2'b00, 0, 0);
    add(0, 1, 4'b1111, 4'b1010, 4'b0010, 2'b01, 1, 1);
    add(0, 1, 4'b1101, 4'b1010, 4'b0000, 2'b01, 0, 0);
    add(0, 1, 4'b1111, 4'b1010, 4'b0100, 2'b10, 1, 0);
    add(0, 1, 4'b1011, 4'b1010, 4'b0000, 2'b10, 0, 0);
    add(0, 1, 4'b1111, 4'b1010, 4'b1000, 2'b11, 1, 1);
    add(0, 1, 4'b0111, 4'b1010, 4'b0000, 2'b11, 0, 0);
    add(0, 1, 4'b1111, 4'b1010, 4'b0001, 2'b00, 1, 0);
    add(0, 1, 4'b0000, 4'b1010, 4'b0000, 2'b00, 0, 0);  // ptr -> 1

    for (int i = 0; i < nv; i++) begin
      reset   = vecs[i].rst;
      req     = vecs[i].req;
      data_in = vecs[i].din;
      if (vecs[i].edge_en) tick();
      else #1;
      chk($sformatf("vec%0d", i), vecs[i].g, vecs[i].s, vecs[i].v, vecs[i].d);
    end

    // timeout with a sole requester: 8 granted, 1 idle, granted again
    data_in = 4'b0000;
    req     = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("timeout_hold%0d", i), 4'b0010, 2'b01, 1, 0);
    end
    tick();
    chk("timeout_dead", 4'b0000, 2'b01, 0, 0);
    tick();
    chk("timeout_regrant", 4'b0010, 2'b01, 1, 0);
    // second requester appears mid-grant: no preemption, then wins after timeout
    req = 4'b0011;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("nopreempt%0d", i), 4'b0010, 2'b01, 1, 0);
    end
    tick();
    chk("timeout2_dead", 4'b0000, 2'b01, 0, 0);
    tick();
    chk("timeout2_next", 4'b0001, 2'b00, 1, 0);
    req = 4'b0000;
    tick();
    chk("timeout2_rel", 4'b0000, 2'b00, 0, 0);  // ptr -> 1

    // reset mid-grant to requester 3 at hold_cnt=4
    data_in = 4'b1111;
    req     = 4'b1000;
    tick();
    chk("midgrant_win3", 4'b1000, 2'b11, 1, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("midgrant_hold%0d", i + 1), 4'b1000, 2'b11, 1, 1);
    end
    reset = 1'b1;
    req   = 4'b1001;
    tick();
    chk("midgrant_reset", 4'b0000, 2'b00, 0, 0);
    reset = 1'b0;
    tick();
    chk("midgrant_ptr0", 4'b0001, 2'b00, 1, 1);
    req = 4'b0000;
    tick();
    chk("midgrant_rel", 4'b0000, 2'b00, 0, 0);  // ptr -> 1

    // pointer skip
    req = 4'b0010;
    tick();
    chk("skip_own1", 4'b0010, 2'b01, 1, 1);
    req = 4'b0001;
    tick();
    chk("skip_rel1", 4'b0000, 2'b01, 0, 0);  // ptr -> 2
    tick();
    chk("skip_wrap0", 4'b0001, 2'b00, 1, 1);
    req = 4'b0000;
    tick();
    chk("skip_rel0", 4'b0000, 2'b00, 0, 0);  // ptr -> 1
    req = 4'b1001;
    tick();
    chk("skip_win3", 4'b1000, 2'b11, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
